// File: rtl/pixel_scaler.sv
// Sprite pixel scaler: replicates each input pixel 2^scale times and packs the chunks into
// line-buffer beats carrying {previous beat, current beat}. Define PIXEL_SCALER_FLIP_EN for in_flip.
module pixel_scaler #(
    parameter int PIX_W  = 8,
    parameter int IN_PIX = 4,
    parameter int LANES  = 16,
    parameter int X_W    = 11
) (
    input  logic                            clk_draw,
    input  logic                            rst_draw_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [IN_PIX*PIX_W-1:0]         in_pixels,
    input  logic [IN_PIX-1:0]               in_mask,
    input  logic [X_W-1:0]                  in_x,
    input  logic [1:0]                      in_scale,
    input  logic                            in_flip,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*LANES*PIX_W-1:0]        out_pixels,
    output logic [2*LANES-1:0]              out_mask,
    output logic [X_W-$clog2(LANES)-1:0]    out_addr,
    output logic [$clog2(LANES)-1:0]        out_shift,
    output logic                            seq_err
);
    localparam int LOG_L     = $clog2(LANES);
    localparam int A_W       = X_W - LOG_L;
    localparam int F_W       = LOG_L + 1;
    localparam int MAX_SCALE = $clog2(LANES / IN_PIX);
    localparam int LINE_W    = LANES * PIX_W;
    localparam int SRC_W     = (IN_PIX > 1) ? $clog2(IN_PIX) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
    state_t state, state_nx;

    logic [F_W-1:0]    fill;
    logic [A_W-1:0]    beat_k;
    logic [1:0]        scale;
    logic [X_W-1:0]    x0;
    logic [LINE_W-1:0] acc_pix, prev_pix;
    logic [LANES-1:0]  acc_mask, prev_mask;

    logic              out_free, accept, restart, take, drop_err, beat_done;
    logic [1:0]        sel_scale;
    logic [F_W-1:0]    base_fill, new_fill;
    logic [A_W-1:0]    sel_k;
    logic [X_W-1:0]    sel_x0;
    logic [LINE_W-1:0] merge_pix, hist_pix;
    logic [LANES-1:0]  merge_mask, hist_mask;
    logic [PIX_W-1:0]  word_pix [IN_PIX];
    logic [IN_PIX-1:0] word_mask;
    logic [SRC_W-1:0]  src_idx;

`ifdef PIXEL_SCALER_FLIP_EN
    always_comb begin
        for (int j = 0; j < IN_PIX; j++) begin
            word_pix[j]  = in_flip ? in_pixels[(IN_PIX-1-j)*PIX_W +: PIX_W] : in_pixels[j*PIX_W +: PIX_W];
            word_mask[j] = in_flip ? in_mask[IN_PIX-1-j] : in_mask[j];
        end
    end
`else
    logic unused_flip;
    assign unused_flip = in_flip;

    always_comb begin
        for (int j = 0; j < IN_PIX; j++) begin
            word_pix[j] = in_pixels[j*PIX_W +: PIX_W];
        end
        word_mask = in_mask;
    end
`endif

    // The FSM never accepts while FLUSH is pending or the output slot is occupied.
    assign out_free = !out_valid || out_ready;
    assign in_ready = rst_draw_n && (state != FLUSH) && out_free;
    assign accept   = in_valid && in_ready;
    assign restart  = accept && in_first;
    assign take     = restart || (accept && state == ACCUM);
    assign drop_err = accept && (in_first ? (state == ACCUM) : (state == IDLE));

    // A sprite start uses this word's x/scale directly and forgets any partial beat and history.
    assign sel_scale = !restart ? scale :
                       (in_scale > 2'(MAX_SCALE)) ? 2'(MAX_SCALE) : in_scale;
    assign base_fill = restart ? '0 : fill;
    assign sel_k     = restart ? '0 : beat_k;
    assign sel_x0    = restart ? in_x : x0;
    assign hist_pix  = restart ? '0 : prev_pix;
    assign hist_mask = restart ? '0 : prev_mask;
    assign new_fill  = base_fill + (F_W'(IN_PIX) << sel_scale);
    assign beat_done = take && ((new_fill == F_W'(LANES)) || in_last);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        merge_pix  = '0;
        merge_mask = '0;
        src_idx    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (F_W'(i) < base_fill) begin
                merge_pix[i*PIX_W +: PIX_W] = acc_pix[i*PIX_W +: PIX_W];
                merge_mask[i]               = acc_mask[i];
            end else if (F_W'(i) < new_fill) begin
                src_idx                     = SRC_W'((i - int'(base_fill)) >> sel_scale);
                merge_pix[i*PIX_W +: PIX_W] = word_pix[src_idx];
                merge_mask[i]               = word_mask[src_idx];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACCUM: if (take) state_nx = (beat_done && in_last) ? FLUSH : ACCUM;
            FLUSH:       if (out_free) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // NOTE: the accumulator and history are plain flops, so they are cleared by reset like any other state.
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state      <= IDLE;
            fill       <= '0;
            beat_k     <= '0;
            scale      <= '0;
            x0         <= '0;
            acc_pix    <= '0;
            acc_mask   <= '0;
            prev_pix   <= '0;
            prev_mask  <= '0;
            seq_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_pixels <= '0;
            out_mask   <= '0;
            out_addr   <= '0;
            out_shift  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= state_nx;
            seq_err <= drop_err;
            if (take) begin
                x0    <= sel_x0;
                scale <= sel_scale;
                if (beat_done) begin
                    fill      <= '0;
                    acc_pix   <= '0;
                    acc_mask  <= '0;
                    prev_pix  <= merge_pix;
                    prev_mask <= merge_mask;
                    beat_k    <= sel_k + 1'b1;
                end else begin
                    fill      <= new_fill;
                    acc_pix   <= merge_pix;
                    acc_mask  <= merge_mask;
                    prev_pix  <= hist_pix;
                    prev_mask <= hist_mask;
                    beat_k    <= sel_k;
                end
            end
            if (beat_done) begin
                out_valid  <= 1'b1;
                out_pixels <= {hist_pix, merge_pix};
                out_mask   <= {hist_mask, merge_mask};
                out_addr   <= sel_x0[X_W-1:LOG_L] + sel_k;
                out_shift  <= sel_x0[LOG_L-1:0];
            end else if (state == FLUSH && out_free) begin
                // Trailing beat lets the downstream finish the last beat's spill into the next word.
                out_valid  <= 1'b1;
                out_pixels <= {prev_pix, {LINE_W{1'b0}}};
                out_mask   <= {prev_mask, {LANES{1'b0}}};
                out_addr   <= x0[X_W-1:LOG_L] + beat_k;
                out_shift  <= x0[LOG_L-1:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_scaler.sv
// Self-checking bench for pixel_scaler: directed scenarios plus randomized sprites and
// backpressure, compared against a queue-based reference model of beat formation.
module tb_pixel_scaler;
    localparam int PIX_W  = 8;
    localparam int IN_PIX = 4;
    localparam int LANES  = 16;
    localparam int X_W    = 11;
    localparam int LINE_W = LANES * PIX_W;
    localparam int MAX_SC = $clog2(LANES / IN_PIX);
`ifdef PIXEL_SCALER_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    typedef struct {
        logic [2*LINE_W-1:0] pix;
        logic [2*LANES-1:0]  mask;
        logic [6:0]          addr;
        logic [3:0]          shift;
    } beat_t;

    logic                     clk_draw = 1'b0;
    logic                     rst_draw_n = 1'b0;
    logic                     in_valid, in_ready, in_first, in_last, in_flip;
    logic [IN_PIX*PIX_W-1:0]  in_pixels;
    logic [IN_PIX-1:0]        in_mask;
    logic [X_W-1:0]           in_x;
    logic [1:0]               in_scale;
    logic                     out_valid, out_ready, seq_err;
    logic [2*LINE_W-1:0]      out_pixels;
    logic [2*LANES-1:0]       out_mask;
    logic [6:0]               out_addr;
    logic [3:0]               out_shift;

    pixel_scaler dut (
        .clk_draw(clk_draw), .rst_draw_n(rst_draw_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .in_pixels(in_pixels), .in_mask(in_mask), .in_x(in_x), .in_scale(in_scale), .in_flip(in_flip),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels), .out_mask(out_mask),
        .out_addr(out_addr), .out_shift(out_shift), .seq_err(seq_err)
    );

    always #5 clk_draw = ~clk_draw;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: sub-pixels collected in a queue, a beat cut at LANES entries or at in_last.
    beat_t               exp_q[$];
    int                  sub_pix[$];
    bit                  sub_mask[$];
    bit                  m_active = 0;
    int                  m_x0, m_sc, m_k;
    logic [LINE_W-1:0]   m_prev_pix;
    logic [LANES-1:0]    m_prev_mask;
    int                  err_exp = 0;
    int                  err_seen = 0;

    task automatic model_emit(input bit flush);
        beat_t b;
        logic [LINE_W-1:0] lp;
        logic [LANES-1:0]  lm;
        lp = '0;
        lm = '0;
        if (!flush) begin
            for (int i = 0; i < sub_pix.size(); i++) begin
                lp[i*PIX_W +: PIX_W] = PIX_W'(sub_pix[i]);
                lm[i]                = sub_mask[i];
            end
        end
        b.pix   = {m_prev_pix, lp};
        b.mask  = {m_prev_mask, lm};
        b.addr  = 7'((m_x0 / LANES) + m_k);
        b.shift = 4'(m_x0 % LANES);
        exp_q.push_back(b);
        m_prev_pix  = lp;
        m_prev_mask = lm;
        m_k++;
        sub_pix.delete();
        sub_mask.delete();
    endtask

    task automatic model_word(input bit f, input bit l, input logic [31:0] p, input logic [3:0] m,
                              input logic [10:0] x, input logic [1:0] s, input bit fl);
        int src;
        if (f) begin
            if (m_active) err_exp++;
            m_active    = 1;
            m_x0        = int'(x);
            m_sc        = (int'(s) > MAX_SC) ? MAX_SC : int'(s);
            m_k         = 0;
            m_prev_pix  = '0;
            m_prev_mask = '0;
            sub_pix.delete();
            sub_mask.delete();
        end else if (!m_active) begin
            err_exp++;
            return;
        end
        for (int j = 0; j < IN_PIX; j++) begin
            src = (FLIP_EN && fl) ? IN_PIX - 1 - j : j;
            for (int r = 0; r < (1 << m_sc); r++) begin
                sub_pix.push_back(int'(p[src*PIX_W +: PIX_W]));
                sub_mask.push_back(m[src]);
            end
        end
        if (sub_pix.size() == LANES || l) model_emit(0);
        if (l) begin
            model_emit(1);
            m_active = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input bit f, input bit l, input logic [31:0] p, input logic [3:0] m,
                        input logic [10:0] x, input logic [1:0] s, input bit fl, output int waits);
        bit ok;
        bit done;
        waits = 0;
        done  = 0;
        in_valid = 1; in_first = f; in_last = l; in_pixels = p; in_mask = m;
        in_x = x; in_scale = s; in_flip = fl;
        while (!done) begin
            #1 ok = in_ready;
            @(posedge clk_draw);
            if (ok) begin
                model_word(f, l, p, m, x, s, fl);
                done = 1;
            end else begin
                waits++;
                if (waits > 500) begin
                    check("in_ready timeout", 256'(in_ready), 256'(1));
                    done = 1;
                end
            end
            @(negedge clk_draw);
        end
        in_valid = 0; in_first = 0; in_last = 0;
    endtask

    bit hold_ready = 0;
    bit rand_stall = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk_draw);
            #1;
            if (!hold_ready) out_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: every transferred beat is matched against the model; stalled beats must hold.
    beat_t               e;
    bit                  was_stall = 0;
    logic [2*LINE_W-1:0] last_pix;
    logic [2*LANES-1:0]  last_mask;
    logic [6:0]          last_addr;

    always @(negedge clk_draw) begin
        if (rst_draw_n) begin
            if (was_stall) begin
                check("hold valid", 256'(out_valid), 256'(1));
                check("hold pix", 256'(out_pixels), 256'(last_pix));
                check("hold mask", 256'(out_mask), 256'(last_mask));
                check("hold addr", 256'(out_addr), 256'(last_addr));
            end
            if (seq_err) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat", 256'(out_valid), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat pix", 256'(out_pixels), 256'(e.pix));
                    check("beat mask", 256'(out_mask), 256'(e.mask));
                    check("beat addr", 256'(out_addr), 256'(e.addr));
                    check("beat shift", 256'(out_shift), 256'(e.shift));
                end
            end
            was_stall = out_valid && !out_ready;
            last_pix  = out_pixels;
            last_mask = out_mask;
            last_addr = out_addr;
        end else begin
            was_stall = 0;
        end
    end

    initial begin
        int w;
        logic [127:0] fwd, rev;
        fwd = 128'h44444444333333332222222211111111;
        rev = 128'h11111111222222223333333344444444;
        in_valid = 0; in_first = 0; in_last = 0; in_pixels = '0; in_mask = '0;
        in_x = '0; in_scale = '0; in_flip = 0;

        #3;
        check("rst in_ready", 256'(in_ready), 256'(0));
        check("rst out_valid", 256'(out_valid), 256'(0));
        check("rst out_mask", 256'(out_mask), 256'(0));
        check("rst out_addr", 256'(out_addr), 256'(0));
        check("rst seq_err", 256'(seq_err), 256'(0));
        repeat (2) @(negedge clk_draw);
        rst_draw_n = 1;

        // Single-word sprite, scale 2, x=0x023.
        send(1, 1, 32'h44332211, 4'hF, 11'h023, 2'd2, 0, w);
        check("s27 valid", 256'(out_valid), 256'(1));
        check("s27 low pix", 256'(out_pixels[127:0]), 256'(fwd));
        check("s27 mask", 256'(out_mask), 256'(32'h0000FFFF));
        check("s27 addr", 256'(out_addr), 256'(2));
        check("s27 shift", 256'(out_shift), 256'(3));
        @(negedge clk_draw);
        check("s27 flush valid", 256'(out_valid), 256'(1));
        check("s27 flush high", 256'(out_pixels[255:128]), 256'(fwd));
        check("s27 flush mask", 256'(out_mask), 256'(32'hFFFF0000));
        check("s27 flush addr", 256'(out_addr), 256'(3));

        // Four words at scale 0 fill exactly one beat.
        for (int i = 0; i < 4; i++) begin
            send(i == 0, i == 3, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
            if (i == 2) check("s28 no early beat", 256'(out_valid), 256'(0));
        end
        check("s28 mask", 256'(out_mask), 256'(32'h0000FFFF));
        @(negedge clk_draw);
        check("s28 flush mask", 256'(out_mask), 256'(32'hFFFF0000));

        // Partial beat on in_last.
        send(1, 0, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        send(0, 1, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        check("s29 mask", 256'(out_mask), 256'(32'h000000FF));
        @(negedge clk_draw);
        check("s29 flush mask", 256'(out_mask), 256'(32'h00FF0000));

        // Full-rate stream at scale 2, then FLUSH costs one cycle.
        send(1, 0, $urandom, 4'hF, 11'h100, 2'd2, 0, w);
        send(0, 0, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        check("tput wait w2", 256'(w), 256'(0));
        send(0, 1, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        check("tput wait w3", 256'(w), 256'(0));
        send(1, 1, $urandom, 4'hA, 11'h7F5, 2'd3, 0, w);
        check("flush cost", 256'(w), 256'(1));
        @(negedge clk_draw);

        // Backpressure for five cycles mid-stream.
        @(posedge clk_draw);
        #1 hold_ready = 1; out_ready = 0;
        @(negedge clk_draw);
        send(1, 0, $urandom, 4'h7, 11'h0A0, 2'd2, 0, w);
        repeat (5) begin
            #1 check("stall in_ready", 256'(in_ready), 256'(0));
            @(negedge clk_draw);
        end
        @(posedge clk_draw);
        #1 hold_ready = 0; out_ready = 1;
        @(negedge clk_draw);
        send(0, 0, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        send(0, 1, $urandom, 4'h9, 11'h000, 2'd0, 0, w);

        // in_first mid-sprite restarts with the same word.
        send(1, 0, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        send(1, 0, $urandom, 4'hF, 11'h040, 2'd0, 0, w);
        check("s31 seq_err", 256'(seq_err), 256'(1));
        check("s31 no beat", 256'(out_valid), 256'(0));
        send(0, 0, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        check("s31 seq_err clr", 256'(seq_err), 256'(0));
        send(0, 0, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        send(0, 1, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        check("s31 new mask", 256'(out_mask), 256'(32'h0000FFFF));
        check("s31 new addr", 256'(out_addr), 256'(4));

        // Flip (reversed only when the feature is built).
        send(1, 1, 32'h44332211, 4'hF, 11'h000, 2'd2, 1, w);
        check("s32 flip low", 256'(out_pixels[127:0]), 256'(FLIP_EN ? rev : fwd));

        // Asynchronous reset mid-sprite.
        send(1, 0, 32'hDEADBEEF, 4'hF, 11'h155, 2'd2, 0, w);
        #2 rst_draw_n = 0;
        #1;
        check("mid rst out_valid", 256'(out_valid), 256'(0));
        check("mid rst pixels", 256'(out_pixels), 256'(0));
        check("mid rst mask", 256'(out_mask), 256'(0));
        check("mid rst addr", 256'(out_addr), 256'(0));
        check("mid rst shift", 256'(out_shift), 256'(0));
        check("mid rst in_ready", 256'(in_ready), 256'(0));
        exp_q.delete();
        sub_pix.delete();
        sub_mask.delete();
        m_active = 0;
        @(negedge clk_draw);
        rst_draw_n = 1;
        send(0, 1, $urandom, 4'hF, 11'h000, 2'd0, 0, w);
        check("post rst no flush", 256'(out_valid), 256'(0));
        @(negedge clk_draw);
        check("post rst idle", 256'(out_valid), 256'(0));

        // Randomized sprites with random backpressure, aborts and orphan words.
        rand_stall = 1;
        for (int sp = 0; sp < 60; sp++) begin
            int  len;
            bit  abort;
            logic [1:0]  sc;
            if ($urandom_range(0, 5) == 0 && !m_active)
                send(0, $urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 15)),
                     11'($urandom), 2'($urandom_range(0, 3)), 0, w);
            len   = $urandom_range(1, 6);
            sc    = 2'($urandom_range(0, 3));
            abort = (sp < 59) && ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++)
                send(i == 0, (i == len - 1) && !abort, $urandom, 4'($urandom_range(0, 15)),
                     11'($urandom), (i == 0) ? sc : 2'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, w);
        end
        rand_stall = 0;

        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(negedge clk_draw);
        @(negedge clk_draw);
        check("drain", 256'(exp_q.size()), 256'(0));
        check("seq_err count", 256'(err_seen), 256'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
